reg_writeback: RTL and testbench

//  Write side of the architectural register bank that the decoder reads for op1/op2/op3.

---
 rtl/reg_writeback_pkg.sv | 17 +
 rtl/reg_writeback_if.sv | 42 ++++
 rtl/reg_writeback_wb_fifo.sv | 56 +++++
 rtl/reg_writeback.sv | 113 +++++++++++
 tb/tb_reg_writeback.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared types for the register write-back slice: register numbers, register
// values and the request word buffered on the memory result port.
package reg_writeback_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 32;
  localparam int RNUM_W   = 5;

  typedef logic [RNUM_W-1:0] register_num_t;
  typedef logic [REG_W-1:0]  register_t;

  typedef struct packed {
    register_num_t rd;
    register_t     data;
  } wb_req_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Decoder/ALU/load-unit facing bundle of the write-back block.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1; valid must not wait for ready, and ready never depends on valid of
// the same port, so there is no combinational loop between the two sides.
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic                         claim_valid;
  register_num_t                claim_rd;
  logic                         claim_ready;
  logic                         alu_valid;
  register_num_t                alu_rd;
  register_t                    alu_result;
  logic                         alu_ready;
  logic                         mem_valid;
  register_num_t                mem_rd;
  register_t                    mem_result;
  logic                         mem_ready;
  logic                         wb_valid;
  register_num_t                wb_rd;
  register_t                    wb_data;
  logic [NUM_REGS-1:0]          pending;
  register_t [NUM_REGS-1:0]     register_bank;
  logic                         wb_error;

  // Write-back block side.
  modport slave (
    input  claim_valid, claim_rd, alu_valid, alu_rd, alu_result,
           mem_valid, mem_rd, mem_result,
    output claim_ready, alu_ready, mem_ready, wb_valid, wb_rd, wb_data,
           pending, register_bank, wb_error
  );

  // Decoder / execution units side.
  modport master (
    output claim_valid, claim_rd, alu_valid, alu_rd, alu_result,
           mem_valid, mem_rd, mem_result,
    input  claim_ready, alu_ready, mem_ready, wb_valid, wb_rd, wb_data,
           pending, register_bank, wb_error
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Small synchronous FIFO buffering load results until the write port is free.
// Pointers and occupancy are async-reset; the storage array is not reset since
// nothing is read from it while empty.
module reg_writeback_wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage write on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy update; simultaneous push+pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Write side of the architectural register bank: one commit per cycle from
// either the ALU (direct) or the load FIFO head, plus a per-register count of
// outstanding writes that the decoder uses to stall on in-flight registers.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int PEND_CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  reg_writeback_if.slave   wb_if
);

  localparam logic [PEND_CNT_W-1:0] CNT_MAX = '1;

  wb_req_t                               head;
  wb_req_t                               mem_req;
  logic                                  fifo_full, fifo_empty;
  logic                                  alu_take, head_take, mem_push;
  logic                                  commit;
  register_num_t                         commit_rd;
  register_t                             commit_data;
  logic                                  claim_ready, claim_fire;
  logic [NUM_REGS-1:0][PEND_CNT_W-1:0]   cnt_q, cnt_d;
  register_t [NUM_REGS-1:0]              bank_q, bank_d;
  logic                                  wb_error_q, wb_error_d;

  assign mem_req  = '{rd: wb_if.mem_rd, data: wb_if.mem_result};
  assign mem_push = wb_if.mem_valid && wb_if.mem_ready;

  reg_writeback_wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (mem_push),
    .push_data_i (mem_req),
    .pop_i       (head_take),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Write-port arbitration: a full FIFO has priority so loads cannot starve.
  always_comb begin
    alu_take  = 1'b0;
    head_take = 1'b0;
    if (!rst) begin
      if (fifo_full)            head_take = 1'b1;
      else if (wb_if.alu_valid) alu_take  = 1'b1;
      else if (!fifo_empty)     head_take = 1'b1;
    end
    commit      = alu_take || head_take;
    commit_rd   = alu_take ? wb_if.alu_rd     : head.rd;
    commit_data = alu_take ? wb_if.alu_result : head.data;
  end

  // A saturated counter only blocks a claim if no commit frees a slot now.
  always_comb begin
    claim_ready = !rst && ((cnt_q[wb_if.claim_rd] != CNT_MAX) ||
                           (commit && (commit_rd == wb_if.claim_rd)));
    claim_fire  = wb_if.claim_valid && claim_ready && (wb_if.claim_rd != '0);
  end

  // Next-state for counters, bank and sticky error; register 0 is never touched.
  always_comb begin
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    wb_error_d = wb_error_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (claim_fire && (wb_if.claim_rd == register_num_t'(i))) begin
        if (!(commit && (commit_rd == register_num_t'(i))))
          cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (commit && (commit_rd == register_num_t'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (commit && (commit_rd != '0)) begin
      bank_d[commit_rd] = commit_data;
      if (cnt_q[commit_rd] == '0) wb_error_d = 1'b1;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bank_q     <= '0;
      wb_error_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      wb_error_q <= wb_error_d;
    end
  end

  // Output drive; ready for both result ports is the registered not-full state.
  always_comb begin
    wb_if.claim_ready   = claim_ready;
    wb_if.alu_ready     = !rst && !fifo_full;
    wb_if.mem_ready     = !rst && !fifo_full;
    wb_if.wb_valid      = commit;
    wb_if.wb_rd         = commit_rd;
    wb_if.wb_data       = commit_data;
    wb_if.register_bank = bank_q;
    wb_if.wb_error      = wb_error_q;
    wb_if.pending       = '0;
    for (int i = 1; i < NUM_REGS; i++) wb_if.pending[i] = (cnt_q[i] != '0);
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: inputs change on the falling edge, outputs
// are checked 1 ns later, so registered results of the previous rising edge and
// combinational write-back signals of the current cycle are both stable.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_writeback_if bus ();

  reg_writeback #(.MEM_FIFO_DEPTH(4), .PEND_CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bank_zero(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s_bank%0d", tag, i), bus.register_bank[i], 32'h0);
  endtask

  task automatic idle();
    bus.claim_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.mem_valid   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] data);
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = rd;
    bus.alu_result = data;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] data);
    bus.mem_valid  = 1'b1;
    bus.mem_rd     = rd;
    bus.mem_result = data;
  endtask

  task automatic claim(input logic [4:0] rd);
    bus.claim_valid = 1'b1;
    bus.claim_rd    = rd;
    step();
    bus.claim_valid = 1'b0;
  endtask

  initial begin
    bus.claim_rd = '0; bus.alu_rd = '0; bus.alu_result = '0;
    bus.mem_rd = '0; bus.mem_result = '0;
    idle();

    // Reset held, then released.
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_claim_ready", 32'(bus.claim_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bank_zero("reset");
    check("reset_pending", bus.pending, 32'h0);
    check("reset_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("reset_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("reset_claim_ready", 32'(bus.claim_ready), 32'd1);
    check("reset_wb_error", 32'(bus.wb_error), 32'd0);
    check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);

    // Claim r5 then ALU write r5.
    claim(5'd5);
    #1;
    check("claim5_pending", 32'(bus.pending[5]), 32'd1);
    alu(5'd5, 32'h12345678);
    #1;
    check("alu5_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("alu5_wb_rd", 32'(bus.wb_rd), 32'd5);
    check("alu5_wb_data", bus.wb_data, 32'h12345678);
    check("alu5_bank_old", bus.register_bank[5], 32'h0);
    step(); idle(); #1;
    check("alu5_bank_new", bus.register_bank[5], 32'h12345678);
    check("alu5_pending", 32'(bus.pending[5]), 32'd0);

    // ALU write to r0.
    alu(5'd0, 32'hDEADBEEF);
    #1;
    check("r0_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("r0_wb_rd", 32'(bus.wb_rd), 32'd0);
    step(); idle(); #1;
    check("r0_bank", bus.register_bank[0], 32'h0);
    check("r0_wb_error", 32'(bus.wb_error), 32'd0);
    check("r0_wb_valid_off", 32'(bus.wb_valid), 32'd0);

    // ALU r3 and mem r4 in the same cycle.
    claim(5'd3);
    claim(5'd4);
    alu(5'd3, 32'h33);
    mem(5'd4, 32'h44);
    #1;
    check("dual_first_rd", 32'(bus.wb_rd), 32'd3);
    check("dual_first_data", bus.wb_data, 32'h33);
    step(); idle(); #1;
    check("dual_second_valid", 32'(bus.wb_valid), 32'd1);
    check("dual_second_rd", 32'(bus.wb_rd), 32'd4);
    check("dual_second_data", bus.wb_data, 32'h44);
    check("dual_bank3", bus.register_bank[3], 32'h33);
    check("dual_bank4_old", bus.register_bank[4], 32'h0);
    step(); #1;
    check("dual_bank4", bus.register_bank[4], 32'h44);
    check("dual_idle", 32'(bus.wb_valid), 32'd0);
    check("dual_pending", bus.pending, 32'h0);

    // Fill the FIFO while the ALU holds the port, then drain in order.
    claim(5'd10); claim(5'd11); claim(5'd12); claim(5'd13);
    alu(5'd0, 32'hA1);
    mem(5'd10, 32'd1);
    #1;
    check("fill_alu_wins", 32'(bus.wb_rd), 32'd0);
    step(); mem(5'd11, 32'd2);
    step(); mem(5'd12, 32'd3);
    step(); mem(5'd13, 32'd4);
    #1;
    check("fill3_mem_ready", 32'(bus.mem_ready), 32'd1);
    step(); bus.mem_valid = 1'b0; #1;
    check("full_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("full_head_rd", 32'(bus.wb_rd), 32'd10);
    check("full_head_data", bus.wb_data, 32'd1);
    step(); #1;
    check("resume_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("resume_alu_rd", 32'(bus.wb_rd), 32'd0);
    check("resume_alu_data", bus.wb_data, 32'hA1);
    step(); bus.alu_valid = 1'b0; #1;
    check("drain2_rd", 32'(bus.wb_rd), 32'd11);
    check("drain2_data", bus.wb_data, 32'd2);
    step(); #1;
    check("drain3_rd", 32'(bus.wb_rd), 32'd12);
    check("drain3_data", bus.wb_data, 32'd3);
    step(); #1;
    check("drain4_rd", 32'(bus.wb_rd), 32'd13);
    check("drain4_data", bus.wb_data, 32'd4);
    step(); #1;
    check("drain_done", 32'(bus.wb_valid), 32'd0);
    check("drain_bank10", bus.register_bank[10], 32'd1);
    check("drain_bank11", bus.register_bank[11], 32'd2);
    check("drain_bank12", bus.register_bank[12], 32'd3);
    check("drain_bank13", bus.register_bank[13], 32'd4);
    check("drain_pending", bus.pending, 32'h0);
    check("drain_wb_error", 32'(bus.wb_error), 32'd0);

    // Two claims of r7, two commits; then an unclaimed commit to r9.
    claim(5'd7); claim(5'd7);
    #1;
    check("claim7x2_pending", 32'(bus.pending[7]), 32'd1);
    alu(5'd7, 32'h77);
    step(); idle(); #1;
    check("r7_one_left", 32'(bus.pending[7]), 32'd1);
    check("r7_bank_first", bus.register_bank[7], 32'h77);
    alu(5'd7, 32'h770);
    step(); idle(); #1;
    check("r7_cleared", 32'(bus.pending[7]), 32'd0);
    check("r7_bank_second", bus.register_bank[7], 32'h770);
    check("r7_no_error", 32'(bus.wb_error), 32'd0);
    alu(5'd9, 32'h99);
    step(); idle(); #1;
    check("r9_error", 32'(bus.wb_error), 32'd1);
    check("r9_bank", bus.register_bank[9], 32'h99);
    check("r9_pending", 32'(bus.pending[9]), 32'd0);
    step(); #1;
    check("r9_error_sticky", 32'(bus.wb_error), 32'd1);

    // Saturate r20, then a same-cycle commit reopens the claim.
    claim(5'd20); claim(5'd20); claim(5'd20);
    bus.claim_valid = 1'b1;
    bus.claim_rd    = 5'd20;
    #1;
    check("sat_claim_ready", 32'(bus.claim_ready), 32'd0);
    alu(5'd20, 32'h20);
    #1;
    check("sat_commit_claim_ready", 32'(bus.claim_ready), 32'd1);
    step(); idle(); #1;
    check("sat_still_full", 32'(bus.claim_ready), 32'd0);
    check("sat_bank20", bus.register_bank[20], 32'h20);
    check("sat_pending20", 32'(bus.pending[20]), 32'd1);

    // Reset with three entries in the FIFO.
    alu(5'd0, 32'h0);
    mem(5'd21, 32'hA);
    step(); mem(5'd22, 32'hB);
    step(); mem(5'd23, 32'hC);
    step(); idle(); #1;
    check("pre_rst_head_rd", 32'(bus.wb_rd), 32'd21);
    rst = 1'b1;
    #1;
    check("in_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("in_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("in_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("in_rst_claim_ready", 32'(bus.claim_ready), 32'd0);
    check("in_rst_wb_error", 32'(bus.wb_error), 32'd0);
    check("in_rst_pending", bus.pending, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check_bank_zero("rst2");
    check("rst2_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst2_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst2_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst2_claim_ready", 32'(bus.claim_ready), 32'd1);
    step(); #1;
    check("rst2_fifo_empty", 32'(bus.wb_valid), 32'd0);
    check("rst2_bank21", bus.register_bank[21], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
